// File: rtl/button_pkg.sv
// Shared types and constants for the button gesture classifier and its downstream consumers.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  // Event codes menu/mode logic can use when it packs the pulses into one field.
  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_LONG   = 2'd1;
  localparam logic [1:0] EV_DOUBLE = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered-history edge detector for an already-synchronous level; rise/fall are combinational.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev_level;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) prev_level <= 1'b0;
    else       prev_level <= level;
  end

  assign rise = level & ~prev_level;
  assign fall = ~level & prev_level;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short/long/double single-cycle pulses.
// Optional build macro BUTTON_AUTOREPEAT_EN adds the long_repeat auto-repeat output.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_COUNTS       = 1000,
  parameter int DOUBLE_GAP_COUNTS = 300,
  parameter int REPEAT_COUNTS     = 200,
  parameter int CNT_W             = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
`ifdef BUTTON_AUTOREPEAT_EN
  output logic long_repeat,
`endif
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNTS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_COUNTS - 1);
  // The timer never needs to exceed the largest threshold, so it parks there instead of wrapping.
  localparam logic [CNT_W-1:0] TIMER_MAX =
    CNT_W'(max3(LONG_COUNTS, DOUBLE_GAP_COUNTS, REPEAT_COUNTS));
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNTS - 1);
`endif

  logic rise, fall;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
  logic             short_nxt, long_nxt, double_nxt, busy_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
  logic             repeat_nxt;
`endif

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .level (button_level),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    // NOTE: every value written here is defaulted first so no path can infer a latch.
    state_nxt  = state;
    timer_inc  = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);
    timer_nxt  = timer_inc;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    repeat_nxt = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        timer_nxt = '0;
        if (rise) state_nxt = PRESSED;
      end
      PRESSED: begin
        // A release on the threshold cycle still counts as a short press.
        if (fall) begin
          state_nxt = WAIT_SECOND;
        end else if (button_level && timer == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end
      end
      LONG_HELD: begin
`ifdef BUTTON_AUTOREPEAT_EN
        if (fall) begin
          state_nxt = IDLE;
        end else if (timer == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          timer_nxt  = '0;
        end
`else
        timer_nxt = '0;
        if (fall) state_nxt = IDLE;
`endif
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_nxt = SECOND_PRESSED;
        end else if (timer == GAP_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        timer_nxt = '0;
        if (fall) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) timer_nxt = '0;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      long_repeat  <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
      busy         <= busy_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
      long_repeat  <= repeat_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Scenario-table bench for button_press_classifier; build with BUTTON_AUTOREPEAT_EN to cover long_repeat.
module tb_button_press_classifier;
  import button_pkg::*;

  localparam int LONG_COUNTS       = 20;
  localparam int DOUBLE_GAP_COUNTS = 8;
  localparam int REPEAT_COUNTS     = 5;
  localparam int CNT_W             = 16;
  localparam int RUN_CYCLES        = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_level = 1'b0;
  logic short_press, long_press, double_press, busy;
  logic long_repeat;

  button_press_classifier #(
    .LONG_COUNTS       (LONG_COUNTS),
    .DOUBLE_GAP_COUNTS (DOUBLE_GAP_COUNTS),
    .REPEAT_COUNTS     (REPEAT_COUNTS),
    .CNT_W             (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_level (button_level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
`ifdef BUTTON_AUTOREPEAT_EN
    .long_repeat  (long_repeat),
`endif
    .busy         (busy)
  );

`ifndef BUTTON_AUTOREPEAT_EN
  assign long_repeat = 1'b0;
`endif

  always #5 clk = ~clk;

  // Cycle t is the interval after the t-th rising edge following reset; level driven in
  // cycle t is sampled at edge t+1. Busy is expected high in [on1,off1) and [on2,off2).
  typedef struct {
    string name;
    logic  init_level;
    int    r1, f1, r2, f2;
    int    rst_cyc;
    int    on1, off1, on2, off2;
  } scen_t;

  typedef struct {
    int         scen;
    int         cyc;
    logic [1:0] kind;
  } ev_t;

  scen_t scens[$];
  ev_t   evs[$];
  ev_t   sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic level_at(input scen_t s, input int t);
    return (t >= s.r1 && t < s.f1) || (t >= s.r2 && t < s.f2);
  endfunction

  function automatic logic busy_at(input scen_t s, input int t);
    return (t >= s.on1 && t < s.off1) || (t >= s.on2 && t < s.off2);
  endfunction

  initial begin
    scen_t      sc;
    logic [3:0] exp_pulse;
    logic [3:0] act_pulse;

    //                name               init  r1  f1  r2  f2 rst  on1 off1 on2 off2
    scens.push_back('{"idle_low",        1'b0, -1, -1, -1, -1, -1, -1, -1, -1, -1});
    scens.push_back('{"rst_hi_rel_low",  1'b1, -1, -1, -1, -1, -1, -1, -1, -1, -1});
    scens.push_back('{"rst_hi_held",     1'b1,  0,  1, -1, -1, -1,  1, 10, -1, -1});
    scens.push_back('{"short",           1'b0, 10, 15, -1, -1, -1, 11, 24, -1, -1});
    scens.push_back('{"long",            1'b0, 10, 50, -1, -1, -1, 11, 51, -1, -1});
    scens.push_back('{"double",          1'b0, 10, 14, 18, 50, -1, 11, 51, -1, -1});
    scens.push_back('{"fall_at_t19",     1'b0, 10, 30, -1, -1, -1, 11, 39, -1, -1});
    scens.push_back('{"fall_at_t20",     1'b0, 10, 31, -1, -1, -1, 11, 32, -1, -1});
    scens.push_back('{"rise_at_gap7",    1'b0, 10, 14, 22, 26, -1, 11, 27, -1, -1});
    scens.push_back('{"rise_after_gap",  1'b0, 10, 14, 23, 26, -1, 11, 23, 24, 35});
    scens.push_back('{"reset_mid_wait",  1'b0, 10, 14, -1, -1, 18, 11, 19, -1, -1});
    scens.push_back('{"fall_at_repeat",  1'b0, 10, 35, -1, -1, -1, 11, 36, -1, -1});

    evs.push_back('{2,  10, EV_SHORT});
    evs.push_back('{3,  24, EV_SHORT});
    evs.push_back('{4,  31, EV_LONG});
`ifdef BUTTON_AUTOREPEAT_EN
    evs.push_back('{4,  36, EV_REPEAT});
    evs.push_back('{4,  41, EV_REPEAT});
    evs.push_back('{4,  46, EV_REPEAT});
`endif
    evs.push_back('{5,  51, EV_DOUBLE});
    evs.push_back('{6,  39, EV_SHORT});
    evs.push_back('{7,  31, EV_LONG});
    evs.push_back('{8,  27, EV_DOUBLE});
    evs.push_back('{9,  23, EV_SHORT});
    evs.push_back('{9,  35, EV_SHORT});
    evs.push_back('{11, 31, EV_LONG});

    for (int s = 0; s < scens.size(); s++) begin
      sc = scens[s];
      foreach (evs[i]) if (evs[i].scen == s) sb.push_back(evs[i]);

      reset        = 1'b1;
      button_level = sc.init_level;
      repeat (3) @(posedge clk);

      for (int t = 0; t < RUN_CYCLES; t++) begin
        @(posedge clk);
        #1;
        reset        = (t == sc.rst_cyc);
        button_level = level_at(sc, t);
        @(negedge clk);

        exp_pulse = '0;
        if (sb.size() > 0 && sb[0].cyc == t) begin
          exp_pulse[sb[0].kind] = 1'b1;
          void'(sb.pop_front());
        end
        act_pulse = '0;
        act_pulse[EV_SHORT]  = short_press;
        act_pulse[EV_LONG]   = long_press;
        act_pulse[EV_DOUBLE] = double_press;
        act_pulse[EV_REPEAT] = long_repeat;

        check($sformatf("%s_pulses_c%0d", sc.name, t), 32'(act_pulse), 32'(exp_pulse));
        check($sformatf("%s_busy_c%0d", sc.name, t), 32'(busy), 32'(busy_at(sc, t)));
      end

      check($sformatf("%s_events_left", sc.name), 32'(sb.size()), 32'd0);
      sb.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
